pzc_peak_reader: RTL and testbench
==================================

PZC_PEAK_READER -- requirements
Module: pzc_peak_reader

Interface
REQ-001 Parameter NBITS_IN, default 46, is the signed PZC sample width.
REQ-002 Parameter ENG_OUT_BITS, default 13, is the unsigned reconstructed energy width.
REQ-003 Parameter BUNCH_POS, default 3564, is the number of bunch positions per orbit.
REQ-004 Parameter G_SHIFT, default 26, is the arithmetic right shift from PZC units to energy units.
REQ-005 Parameter THRESH, default 2**26, is the signed minimum peak amplitude.
REQ-006 Parameter FIFO_DEPTH, default 16 (power of two), is the number of output record slots.
REQ-007 Parameter MASK_EN, default 1, when 1 accepts peaks only in filled bunches.
REQ-008 clk  in  1  sole clock; all logic is rising-edge.
REQ-009 rst  in  1  reset; asynchronous and active-low.
REQ-010 in  in  NBITS_IN signed  PZC sample, one per clk.
REQ-011 bt_mask_in  in  1  bunch-train mask aligned with in.
REQ-012 orbit_sync  in  1  one-cycle pulse marking bunch position 0 for the sample on in.
REQ-013 out_data  out  12+ENG_OUT_BITS+1  record {bcid[11:0], energy, sat}.
REQ-014 out_valid  out  1  record available.
REQ-015 out_ready  in  1  consumer accepts record when out_valid&out_ready.
REQ-016 overflow_cnt  out  16  count of peaks dropped on full FIFO.

Function
REQ-017 The block SHALL capture in, bt_mask_in and the current bcid into a 3-deep shift window (s0 newest, s1, s2) every clk.
REQ-018 bcid SHALL increment each clk and wrap from BUNCH_POS-1 to 0; orbit_sync SHALL force the captured bcid to 0 and the counter to 1 next cycle.
REQ-019 A peak SHALL be declared on s1 when s1 > THRESH, s1 >= s2, s1 > s0, and (MASK_EN==0 or mask of s1 ==1).
REQ-020 Plateaus SHALL yield exactly one peak, at the last sample of the plateau.
REQ-021 energy SHALL be s1 >>> G_SHIFT clamped to [0, 2**ENG_OUT_BITS-1]; sat SHALL be 1 when clamping to the maximum occurred.
REQ-022 The record SHALL carry the bcid captured with s1, not the current bcid.
REQ-023 A peak detected after edge k SHALL be written to the FIFO at edge k+1; out_valid SHALL be high after edge k+1 if the FIFO was empty (first-word-fall-through).
REQ-024 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 When full and no pop occurs, the new record SHALL be dropped and overflow_cnt SHALL increment, saturating at 65535.
REQ-026 When full and a pop occurs in the same cycle, the write SHALL succeed and no drop is counted.
REQ-027 Simultaneous push and pop on empty FIFO SHALL bypass nothing: the record appears one cycle later.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH with one extra bit distinguishing full from empty.

Reset
REQ-029 rst low SHALL asynchronously clear window, bcid (to 0), FIFO pointers, overflow_cnt, out_valid; out_data SHALL read 0.
REQ-030 A peak in the window at reset assertion SHALL be discarded; detection SHALL restart needing three fresh samples.
REQ-031 Reset release SHALL be synchronized so the first capture occurs on the second clk edge after deassertion.

Structure
REQ-032 Record field widths, bcid width (12) and record packing order SHALL live in package pzc_reader_pkg.
REQ-033 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty.
REQ-034 Peak detection, clamping and bcid counting SHALL reside in pzc_peak_reader.

Verification
REQ-035 in = 0,0,3*2**26,5*2**26,2*2**26,0, mask=1 -> one record energy=5, sat=0, bcid of the 5*2**26 sample, out_valid two edges after its capture.
REQ-036 Peak 2**40 -> energy=8191, sat=1.
REQ-037 Plateau 4*2**26 for 3 samples then 0 -> exactly one record, bcid of third plateau sample.
REQ-038 orbit_sync pulse then peak 10 samples later -> bcid=10; free-run 3564 cycles -> bcid wraps 3563->0.
REQ-039 out_ready=0, 20 isolated peaks -> 16 records held, overflow_cnt=4; then drain -> 16 records in order.
REQ-040 MASK_EN=1, peak with mask=0 -> no record; rst pulsed mid-peak -> no record, counters 0.

Source files
------------

// File: rtl/pzc_reader_pkg.sv
// Shared record layout and control types for the PZC peak reader.
// Records are packed MSB-first as {bcid, energy, sat}.
package pzc_reader_pkg;

  localparam int unsigned BCID_W     = 12;
  localparam int unsigned SAT_W      = 1;
  localparam int unsigned SAT_LSB    = 0;
  localparam int unsigned ENERGY_LSB = SAT_LSB + SAT_W;

  function automatic int unsigned bcid_lsb(input int unsigned eng_w);
    return ENERGY_LSB + eng_w;
  endfunction

  function automatic int unsigned rec_w(input int unsigned eng_w);
    return BCID_W + eng_w + SAT_W;
  endfunction

  typedef enum logic {
    RUN_HOLD,
    RUN_ACTIVE
  } run_state_e;

endpackage

// File: rtl/pzc_peak_reader_if.sv
// Valid/ready record stream leaving the peak reader.
interface pzc_peak_reader_if #(
  parameter int unsigned WIDTH = 26
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; read data is zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pzc_peak_reader.sv
// Finds local maxima in the PZC sample stream, converts them to clamped
// energies tagged with their bunch id, and queues the records for readout.
module pzc_peak_reader
  import pzc_reader_pkg::*;
#(
  parameter int unsigned                NBITS_IN     = 46,
  parameter int unsigned                ENG_OUT_BITS = 13,
  parameter int unsigned                BUNCH_POS    = 3564,
  parameter int unsigned                G_SHIFT      = 26,
  parameter logic signed [NBITS_IN-1:0] THRESH       = NBITS_IN'(2**26),
  parameter int unsigned                FIFO_DEPTH   = 16,
  parameter bit                         MASK_EN      = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [NBITS_IN-1:0] in,
  input  logic                       bt_mask_in,
  input  logic                       orbit_sync,
  pzc_peak_reader_if.master          out_if,
  output logic [15:0]                overflow_cnt
);
  localparam int unsigned REC_W     = rec_w(ENG_OUT_BITS);
  localparam int unsigned BCID_LSB  = bcid_lsb(ENG_OUT_BITS);
  localparam logic [BCID_W-1:0] BCID_LAST = BCID_W'(BUNCH_POS - 1);
  localparam logic signed [NBITS_IN-1:0] ENG_MAX = NBITS_IN'(2**ENG_OUT_BITS - 1);

  run_state_e state_q, state_d;
  logic       run;

  logic signed [NBITS_IN-1:0] s0, s1, s2;
  logic                       mask0, mask1;
  logic [2:0]                 vld;
  logic [BCID_W-1:0]          bcid0, bcid1;
  logic [BCID_W-1:0]          bcid_q, bcid_cap, bcid_nxt;

  logic signed [NBITS_IN-1:0] shifted;
  logic [ENG_OUT_BITS-1:0]    energy;
  logic                       sat;
  logic                       peak;
  logic [REC_W-1:0]           rec;
  logic                       fifo_full, fifo_empty, pop, drop;

  // Deassertion is taken through one register so capture starts on the second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN_HOLD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      RUN_HOLD:   state_d = RUN_ACTIVE;
      RUN_ACTIVE: run     = 1'b1;
      default:    state_d = RUN_HOLD;
    endcase
  end

  always_comb begin
    bcid_cap = orbit_sync ? '0 : bcid_q;
    bcid_nxt = (bcid_cap == BCID_LAST) ? '0 : bcid_cap + 1'b1;
  end

  // vld tracks how many post-reset samples fill the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0     <= '0;
      s1     <= '0;
      s2     <= '0;
      mask0  <= 1'b0;
      mask1  <= 1'b0;
      vld    <= '0;
      bcid0  <= '0;
      bcid1  <= '0;
      bcid_q <= '0;
    end else if (run) begin
      s2     <= s1;
      s1     <= s0;
      s0     <= in;
      mask1  <= mask0;
      mask0  <= bt_mask_in;
      vld    <= {vld[1:0], 1'b1};
      bcid1  <= bcid0;
      bcid0  <= bcid_cap;
      bcid_q <= bcid_nxt;
    end
  end

  // >= toward the older sample and > toward the newer one puts a plateau's peak on its last sample.
  always_comb begin
    peak = (&vld) && (s1 > THRESH) && (s1 >= s2) && (s1 > s0) && (!MASK_EN || mask1);
  end

  always_comb begin
    shifted = s1 >>> G_SHIFT;
    energy  = '0;
    sat     = 1'b0;
    if (shifted[NBITS_IN-1]) begin
      energy = '0;
    end else if (shifted > ENG_MAX) begin
      energy = '1;
      sat    = 1'b1;
    end else begin
      energy = shifted[ENG_OUT_BITS-1:0];
    end
  end

  always_comb begin
    rec                            = '0;
    rec[SAT_LSB]                   = sat;
    rec[ENERGY_LSB +: ENG_OUT_BITS] = energy;
    rec[BCID_LSB +: BCID_W]        = bcid1;
  end

  assign out_if.out_valid = !fifo_empty;
  assign pop              = out_if.out_valid && out_if.out_ready;
  assign drop             = peak && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (peak),
    .push_data (rec),
    .pop       (pop),
    .pop_data  (out_if.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            overflow_cnt <= '0;
    else if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pzc_peak_reader.sv
// Bench for pzc_peak_reader: directed scenarios plus random traffic checked
// against a sample-history/record-queue reference model.
module tb_pzc_peak_reader;
  import pzc_reader_pkg::*;

  localparam int unsigned NB = 46;
  localparam int unsigned EB = 13;
  localparam int unsigned BP = 3564;
  localparam int unsigned FD = 16;
  localparam int unsigned RW = rec_w(EB);
  localparam longint      P  = 64'sd67108864;
  localparam longint      TH = P;

  typedef struct {
    longint      v;
    bit          m;
    int unsigned bcid;
  } samp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [NB-1:0] in_v = '0;
  logic                 mask_v = 1'b1;
  logic                 sync_v = 1'b0;
  logic [15:0]          ovf;

  pzc_peak_reader_if #(.WIDTH(RW)) out_if ();

  pzc_peak_reader #(
    .NBITS_IN     (NB),
    .ENG_OUT_BITS (EB),
    .BUNCH_POS    (BP),
    .G_SHIFT      (26),
    .THRESH       (46'(67108864)),
    .FIFO_DEPTH   (FD),
    .MASK_EN      (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .in           (in_v),
    .bt_mask_in   (mask_v),
    .orbit_sync   (sync_v),
    .out_if       (out_if),
    .overflow_cnt (ovf)
  );

  always #5 clk = ~clk;

  samp_t         hist[$];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int unsigned   pos = 0;
  bit            skip = 1'b0;
  bit            pend = 1'b0;
  logic [RW-1:0] pend_rec;
  int unsigned   ovf_m = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [RW-1:0] make_rec(input int unsigned bcid, input longint v);
    longint e;
    bit     s;
    e = v / P;
    s = (e > 8191);
    if (s)     e = 8191;
    if (e < 0) e = 0;
    return {12'(bcid), 13'(e), s};
  endfunction

  // One clock: check the stream, update the reference model, advance the DUT.
  task automatic step();
    bit    pop_now;
    samp_t s;
    checks++;
    if (out_if.out_valid !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_if.out_valid, exp_q.size() > 0, $time);
    end
    pop_now = out_if.out_ready && (exp_q.size() > 0);
    if (pop_now) begin
      got_q.push_back(out_if.out_data);
      checks++;
      if (out_if.out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL out_data: got %h expected %h at %0t", out_if.out_data, exp_q[0], $time);
      end
      void'(exp_q.pop_front());
    end
    if (pend) begin
      if (exp_q.size() < FD) exp_q.push_back(pend_rec);
      else if (ovf_m < 65535) ovf_m++;
      pend = 1'b0;
    end
    if (skip) begin
      skip = 1'b0;
    end else begin
      s.bcid = sync_v ? 0 : pos;
      pos    = (s.bcid + 1) % BP;
      s.v    = longint'(in_v);
      s.m    = mask_v;
      hist.push_back(s);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3 && hist[1].v > TH && hist[1].v >= hist[0].v &&
          hist[1].v > hist[2].v && hist[1].m) begin
        pend     = 1'b1;
        pend_rec = make_rec(hist[1].bcid, hist[1].v);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (ovf !== 16'(ovf_m)) begin
      errors++;
      $display("FAIL overflow_cnt: got %0d expected %0d at %0t", ovf, ovf_m, $time);
    end
  endtask

  task automatic feed(input longint v, input bit m, input bit sync);
    in_v   = NB'(v);
    mask_v = m;
    sync_v = sync;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) feed(0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hist.delete();
    exp_q.delete();
    pend  = 1'b0;
    ovf_m = 0;
    pos   = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    skip  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_if.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_if.out_valid); end
    checks++;
    if (out_if.out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_if.out_data); end
    checks++;
    if (ovf !== 16'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ovf); end
    rst_n = 1'b1;
    skip  = 1'b1;
    // First edge after release must be ignored: 7P is then at bcid 1, not 2.
    got_q.delete();
    feed(0, 1'b1, 1'b0);
    feed(5 * P, 1'b1, 1'b0);
    feed(7 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != 1 || got_q[0][25:14] !== 12'd1 || got_q[0][13:1] !== 13'd7) begin
      errors++;
      $display("FAIL reset_release: got n=%0d rec=%h expected n=1 bcid=1 energy=7", got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
    end
  endtask

  task automatic test_basic();
    int unsigned b;
    out_if.out_ready = 1'b1;
    got_q.delete();
    feed(0, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    feed(3 * P, 1'b1, 1'b0);
    b = pos;
    feed(5 * P, 1'b1, 1'b0);
    feed(2 * P, 1'b1, 1'b0);
    checks++;
    if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", out_if.out_valid); end
    feed(0, 1'b1, 1'b0);
    checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== {12'(b), 13'd5, 1'b0}) begin
      errors++;
      $display("FAIL basic_record: got v=%b %h expected v=1 %h", out_if.out_valid, out_if.out_data, {12'(b), 13'd5, 1'b0});
    end
    idle(4);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", got_q.size()); end
  endtask

  task automatic test_saturation();
    got_q.delete();
    feed(0, 1'b1, 1'b0);
    feed(64'sd1 << 40, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != 1 || got_q[0][13:0] !== {13'd8191, 1'b1}) begin
      errors++;
      $display("FAIL saturation: got n=%0d rec=%h expected energy=8191 sat=1", got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
    end
  endtask

  task automatic test_plateau();
    int unsigned b;
    got_q.delete();
    feed(0, 1'b1, 1'b0);
    feed(4 * P, 1'b1, 1'b0);
    feed(4 * P, 1'b1, 1'b0);
    b = pos;
    feed(4 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {12'(b), 13'd4, 1'b0}) begin
      errors++;
      $display("FAIL plateau: got n=%0d rec=%h expected n=1 %h", got_q.size(), got_q.size() > 0 ? got_q[0] : '0, {12'(b), 13'd4, 1'b0});
    end
  endtask

  task automatic test_orbit_sync();
    int guard;
    got_q.delete();
    feed(0, 1'b1, 1'b1);
    idle(9);
    feed(5 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 1 || got_q[0][25:14] !== 12'd10) begin
      errors++;
      $display("FAIL orbit_bcid: got n=%0d rec=%h expected bcid=10", got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
    end
    got_q.delete();
    guard = 0;
    while (pos != 3561 && guard < 4000) begin
      feed(0, 1'b1, 1'b0);
      guard++;
    end
    feed(0, 1'b1, 1'b0);
    feed(5 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    feed(5 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != 2 || got_q[0][25:14] !== 12'd3562 || got_q[1][25:14] !== 12'd0) begin
      errors++;
      $display("FAIL bcid_wrap: got n=%0d expected bcids 3562,0", got_q.size());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    out_if.out_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      feed((i + 2) * P, 1'b1, 1'b0);
      feed(0, 1'b1, 1'b0);
    end
    idle(3);
    checks++;
    if (ovf !== 16'd4) begin errors++; $display("FAIL overflow_count: got %0d expected 4", ovf); end
    checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data[13:1] !== 13'd2) begin
      errors++;
      $display("FAIL overflow_hold: got v=%b energy=%0d expected v=1 energy=2", out_if.out_valid, out_if.out_data[13:1]);
    end
    out_if.out_ready = 1'b1;
    idle(20);
    ok = (got_q.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (got_q[i][13:1] !== 13'(i + 2)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL overflow_drain: got n=%0d expected 16 records energies 2..17 in order", got_q.size()); end
  endtask

  task automatic test_mask();
    got_q.delete();
    feed(0, 1'b1, 1'b0);
    feed(5 * P, 1'b0, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL mask_block: got %0d records expected 0", got_q.size()); end
    feed(6 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != 1 || got_q[0][13:1] !== 13'd6) begin
      errors++;
      $display("FAIL mask_pass: got n=%0d expected 1 record energy=6", got_q.size());
    end
  endtask

  task automatic test_reset_mid_peak();
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      feed(3 * P, 1'b1, 1'b0);
      feed(0, 1'b1, 1'b0);
    end
    feed(5 * P, 1'b1, 1'b0);
    feed(2 * P, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (ovf !== 16'd0 || out_if.out_valid !== 1'b0 || out_if.out_data !== '0) begin
      errors++;
      $display("FAIL reset_async: got ovf=%0d v=%b data=%h expected 0 0 0", ovf, out_if.out_valid, out_if.out_data);
    end
    do_reset();
    out_if.out_ready = 1'b1;
    got_q.delete();
    feed(5 * P, 1'b1, 1'b0);
    feed(0, 1'b1, 1'b0);
    idle(5);
    checks++;
    if (got_q.size() != 0 || ovf !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_peak: got n=%0d ovf=%0d expected 0 0", got_q.size(), ovf);
    end
  endtask

  task automatic test_random();
    int unsigned r;
    longint      v;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      v = -(longint'($urandom_range(1, 1000)) << 20);
      else if (r == 1) v = longint'($urandom_range(1, 1 << 20)) << 20;
      else             v = longint'($urandom_range(0, 6)) << 25;
      out_if.out_ready = ($urandom_range(0, 3) != 0);
      feed(v, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
    end
    out_if.out_ready = 1'b1;
    idle(25);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    out_if.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_plateau();
    test_orbit_sync();
    test_overflow();
    test_mask();
    test_reset_mid_peak();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
